// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// Block geometry, FSM states and fill owner encoding.
package mem_arb_pkg;

  localparam int ADDR_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int CNT_W       = 3;

  localparam logic [ADDR_W-1:0] BLOCK_OFFSET_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL,
    DONE
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/fill_counter.sv
// Block word counter with clear, enable and terminal flag.
// Saturates at BLOCK_WORDS, which needs the extra MSB.
module fill_counter
  import mem_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [CNT_W:0] cnt_o,
  output logic           term_o
);

  localparam logic [CNT_W:0] TERM = (CNT_W+1)'(BLOCK_WORDS);

  logic [CNT_W:0] cnt_q;
  logic [CNT_W:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !term_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory sequencer for I/D cache fills and D stores.
// Reads are issued back to back; returns are counted, not timed.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [ADDR_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [ADDR_W-1:0] fill_data,
  output logic [CNT_W-1:0]  fill_word,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic              tag_we_i,
  output logic              tag_we_d,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  localparam logic [CNT_W:0] LAST = (CNT_W+1)'(BLOCK_WORDS - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [CNT_W:0]    issue_cnt;
  logic              issue_term;
  logic [CNT_W:0]    recv_cnt;
  logic              recv_term;
  logic              in_fill;
  logic              cnt_clr;
  logic              rd_take;
  logic [ADDR_W-1:0] rd_off;

  assign in_fill = (state_q == FILL);
  assign cnt_clr = (state_q == DONE);
  assign rd_take = in_fill && mem_rvalid && !recv_term;
  assign rd_off  = {{(ADDR_W-CNT_W-1){1'b0}}, issue_cnt} << 1;

  fill_counter u_issue (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (in_fill),
    .cnt_o  (issue_cnt),
    .term_o (issue_term)
  );

  fill_counter u_recv (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (rd_take),
    .cnt_o  (recv_cnt),
    .term_o (recv_term)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    fill_we_i   = 1'b0;
    fill_we_d   = 1'b0;
    tag_we_i    = 1'b0;
    tag_we_d    = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss_req) begin
          state_d = FILL;
          owner_d = OWN_D;
          base_d  = d_miss_addr & BLOCK_OFFSET_MASK;
        end else if (i_miss_req) begin
          state_d = FILL;
          owner_d = OWN_I;
          base_d  = i_miss_addr & BLOCK_OFFSET_MASK;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = IDLE;
      end
      FILL: begin
        if (!issue_term) begin
          mem_en   = 1'b1;
          mem_addr = base_q + rd_off;
        end
        if (rd_take) begin
          fill_data = mem_rdata;
          fill_word = recv_cnt[CNT_W-1:0];
          fill_we_i = (owner_q == OWN_I);
          fill_we_d = (owner_q == OWN_D);
          if (recv_cnt == LAST) begin
            tag_we_i = (owner_q == OWN_I);
            tag_we_d = (owner_q == OWN_D);
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        i_fill_done = (owner_q == OWN_I);
        d_fill_done = (owner_q == OWN_D);
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a pipelined memory model.
// Transaction-level scoreboard: expected service order vs observed events.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d;
  logic        i_fill_done, d_fill_done, d_wr_ack, busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss_req  (i_miss_req),
    .i_miss_addr (i_miss_addr),
    .d_miss_req  (d_miss_req),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .fill_data   (fill_data),
    .fill_word   (fill_word),
    .fill_we_i   (fill_we_i),
    .fill_we_d   (fill_we_d),
    .tag_we_i    (tag_we_i),
    .tag_we_d    (tag_we_d),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_ack    (d_wr_ack),
    .busy        (busy)
  );

  typedef struct { int c; logic [15:0] a; logic [15:0] d; } ev_t;
  typedef struct { int c; logic s; logic [2:0] w; logic [15:0] d; } fw_t;
  typedef struct { int k; logic [15:0] a; logic [15:0] d; } op_t;
  typedef struct { int due; logic [15:0] a; } rd_t;

  localparam int OP_WR = 0;
  localparam int OP_FI = 1;
  localparam int OP_FD = 2;

  ev_t  rdl[$];
  ev_t  wrl[$];
  int   ackl[$];
  fw_t  fwl[$];
  fw_t  tgl[$];
  fw_t  donel[$];
  rd_t  mq[$];
  op_t  ops[$];
  int   op_first[8];
  int   op_done[8];
  int   op_fw0[8];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_due = 0;
  int   lat_min = 4;
  int   lat_max = 4;
  int   busy_last = 0;
  logic [15:0] salt;
  bit   i_seen, d_seen, a_seen;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mdata(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  task automatic mon();
    int due;
    @(negedge clk);
    if (busy) busy_last = cyc;
    if (mem_en && !mem_wr) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{due, mem_addr});
      rdl.push_back('{cyc, mem_addr, 16'h0});
    end
    if (mem_en && mem_wr) wrl.push_back('{cyc, mem_addr, mem_wdata});
    if (d_wr_ack) begin
      ackl.push_back(cyc);
      a_seen = 1;
    end
    if (fill_we_i) fwl.push_back('{cyc, 1'b0, fill_word, fill_data});
    if (fill_we_d) fwl.push_back('{cyc, 1'b1, fill_word, fill_data});
    if (tag_we_i) tgl.push_back('{cyc, 1'b0, 3'd0, 16'h0});
    if (tag_we_d) tgl.push_back('{cyc, 1'b1, 3'd0, 16'h0});
    if (i_fill_done) begin
      donel.push_back('{cyc, 1'b0, 3'd0, 16'h0});
      i_seen = 1;
    end
    if (d_fill_done) begin
      donel.push_back('{cyc, 1'b1, 3'd0, 16'h0});
      d_seen = 1;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    if (i_seen) i_miss_req = 1'b0;
    if (d_seen) d_miss_req = 1'b0;
    if (a_seen) d_wr_req = 1'b0;
    i_seen = 0;
    d_seen = 0;
    a_seen = 0;
    if (mq.size() != 0 && mq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mdata(mq[0].a);
      void'(mq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
  endtask

  task automatic tick();
    mon();
    adv();
  endtask

  task automatic clear_logs();
    rdl.delete();
    wrl.delete();
    ackl.delete();
    fwl.delete();
    tgl.delete();
    donel.delete();
    ops.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || i_miss_req || d_miss_req || d_wr_req ||
            mq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 400, 1);
  endtask

  task automatic check_ops();
    int          prev;
    int          last;
    int          ac;
    logic        s;
    logic [15:0] base;
    logic [15:0] ad;
    ev_t         w;
    fw_t         f;
    prev = -1;
    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i].k == OP_WR) begin
        chk("wr_seen", wrl.size() != 0 && ackl.size() != 0, 1);
        if (wrl.size() != 0 && ackl.size() != 0) begin
          w  = wrl.pop_front();
          ac = ackl.pop_front();
          chk("wr_addr", w.a, ops[i].a);
          chk("wr_data", w.d, ops[i].d);
          chk("ack_cyc", ac, w.c);
          chk("wr_order", w.c > prev, 1);
          op_first[i] = w.c;
          op_done[i]  = w.c;
          prev        = w.c;
        end
      end else begin
        s    = (ops[i].k == OP_FD);
        base = ops[i].a & 16'hFFF0;
        last = 0;
        for (int j = 0; j < 8; j++) begin
          ad = base + 16'(2 * j);
          chk("rd_seen", rdl.size() != 0, 1);
          if (rdl.size() != 0) begin
            w = rdl.pop_front();
            chk("rd_addr", w.a, ad);
            if (j == 0) begin
              chk("rd_order", w.c > prev, 1);
              op_first[i] = w.c;
            end
          end
        end
        for (int j = 0; j < 8; j++) begin
          ad = base + 16'(2 * j);
          chk("fw_seen", fwl.size() != 0, 1);
          if (fwl.size() != 0) begin
            f = fwl.pop_front();
            chk("fw_side", f.s, s);
            chk("fw_word", f.w, j);
            chk("fw_data", f.d, mdata(ad));
            if (j == 0) op_fw0[i] = f.c;
            last = f.c;
          end
        end
        chk("tag_seen", tgl.size() != 0, 1);
        if (tgl.size() != 0) begin
          f = tgl.pop_front();
          chk("tag_cyc", f.c, last);
          chk("tag_side", f.s, s);
        end
        chk("done_seen", donel.size() != 0, 1);
        if (donel.size() != 0) begin
          f = donel.pop_front();
          chk("done_cyc", f.c, last + 1);
          chk("done_side", f.s, s);
          op_done[i] = f.c;
          prev       = f.c;
        end
      end
    end
    chk("extra_events", rdl.size() + wrl.size() + ackl.size() +
        fwl.size() + tgl.size() + donel.size(), 0);
  endtask

  function automatic logic [63:0] outs();
    return {4'h0, mem_en, mem_wr, mem_addr, mem_wdata, fill_data,
            fill_word, fill_we_i, fill_we_d, tag_we_i, tag_we_d,
            i_fill_done, d_fill_done, d_wr_ack, busy};
  endfunction

  initial begin
    int r;
    int m;
    rst         = 1'b1;
    i_miss_req  = 1'b0;
    d_miss_req  = 1'b0;
    d_wr_req    = 1'b0;
    i_miss_addr = '0;
    d_miss_addr = '0;
    d_wr_addr   = '0;
    d_wr_data   = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    salt        = 16'($urandom);

    tick();
    tick();
    rst = 1'b0;
    mon();
    chk("reset_outputs", outs(), 64'd0);
    adv();
    clear_logs();

    // reference latency, I side
    lat_min = 4;
    lat_max = 4;
    i_miss_addr = 16'h0136;
    i_miss_req  = 1'b1;
    r = cyc;
    wait_idle();
    ops.push_back('{OP_FI, 16'h0136, 16'h0});
    check_ops();
    chk("lat_first_rd", op_first[0], r + 1);
    chk("lat_first_fw", op_fw0[0], r + 5);
    chk("lat_done", op_done[0], r + 13);
    chk("lat_busy_end", busy_last, r + 13);
    clear_logs();

    // simultaneous misses
    lat_min = 2;
    lat_max = 6;
    i_miss_addr = 16'($urandom);
    d_miss_addr = 16'($urandom);
    i_miss_req  = 1'b1;
    d_miss_req  = 1'b1;
    wait_idle();
    ops.push_back('{OP_FD, d_miss_addr, 16'h0});
    ops.push_back('{OP_FI, i_miss_addr, 16'h0});
    check_ops();
    chk("i_after_d", op_first[1], op_done[0] + 2);
    clear_logs();

    // store arriving mid-fill waits for DONE
    i_miss_addr = 16'($urandom);
    i_miss_req  = 1'b1;
    repeat (3) tick();
    d_wr_addr = 16'h2004;
    d_wr_data = 16'hBEEF;
    d_wr_req  = 1'b1;
    wait_idle();
    ops.push_back('{OP_FI, i_miss_addr, 16'h0});
    ops.push_back('{OP_WR, 16'h2004, 16'hBEEF});
    check_ops();
    chk("wr_after_fill", op_first[1], op_done[0] + 2);
    clear_logs();

    // store and D miss together
    d_wr_addr   = 16'($urandom);
    d_wr_data   = 16'($urandom);
    d_miss_addr = 16'($urandom);
    d_wr_req    = 1'b1;
    d_miss_req  = 1'b1;
    wait_idle();
    ops.push_back('{OP_WR, d_wr_addr, d_wr_data});
    ops.push_back('{OP_FD, d_miss_addr, 16'h0});
    check_ops();
    chk("fill_after_wr", op_first[1], op_first[0] + 2);
    clear_logs();

    // reset in the middle of a fill
    lat_min = 4;
    lat_max = 4;
    i_miss_addr = 16'($urandom);
    i_miss_req  = 1'b1;
    r = cyc;
    while (cyc < r + 7) tick();
    rst        = 1'b1;
    i_miss_req = 1'b0;
    tick();
    rst = 1'b0;
    mon();
    chk("abort_outputs", outs(), 64'd0);
    adv();
    clear_logs();
    wait_idle();
    chk("stale_fill_we", fwl.size(), 0);
    chk("stale_tag_we", tgl.size(), 0);
    chk("stale_done", donel.size(), 0);
    clear_logs();

    // block at top of address space
    lat_min = 1;
    lat_max = 10;
    d_miss_addr = 16'hFFFA;
    d_miss_req  = 1'b1;
    wait_idle();
    ops.push_back('{OP_FD, 16'hFFFA, 16'h0});
    check_ops();
    clear_logs();

    // random request mixes, served in priority order
    for (int it = 0; it < 25; it++) begin
      lat_min = 1;
      lat_max = int'($urandom_range(10, 1));
      m = int'($urandom_range(7, 1));
      i_miss_addr = 16'($urandom);
      d_miss_addr = 16'($urandom);
      d_wr_addr   = 16'($urandom);
      d_wr_data   = 16'($urandom);
      if (m[0]) begin
        d_wr_req = 1'b1;
        ops.push_back('{OP_WR, d_wr_addr, d_wr_data});
      end
      if (m[1]) begin
        d_miss_req = 1'b1;
        ops.push_back('{OP_FD, d_miss_addr, 16'h0});
      end
      if (m[2]) begin
        i_miss_req = 1'b1;
        ops.push_back('{OP_FI, i_miss_addr, 16'h0});
      end
      wait_idle();
      check_ops();
      clear_logs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-ported, pipelined main memory that the I-cache and D-cache share.
- Arbitrates I-side miss fills, D-side miss fills and D-side write-through stores.
- Performs 8-word block fills: issues one read per cycle and steers returned words into the requesting cache's data array and tag array.
- Sits between the cache miss logic and the main memory model, below the pipeline stall logic.

Parameters:
ADDR_W, 16, address/data width in bits
BLOCK_WORDS, 8, 16-bit words per cache block (power of 2)
CNT_W, 3, log2(BLOCK_WORDS), width of the word counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_miss_req  in  1  I-cache miss; held high until i_fill_done
i_miss_addr  in  16  I-side miss byte address; stable while req high
d_miss_req  in  1  D-cache miss; held high until d_fill_done
d_miss_addr  in  16  D-side miss byte address
d_wr_req  in  1  write-through store request; held until d_wr_ack
d_wr_addr  in  16  store byte address
d_wr_data  in  16  store data
mem_en  out  1  memory access enable
mem_wr  out  1  memory write (1) / read (0)
mem_addr  out  16  memory byte address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
mem_rvalid  in  1  mem_rdata valid this cycle
fill_data  out  16  word to write into the cache data array
fill_word  out  3  word index within the block for fill_data
fill_we_i  out  1  I-cache data array write enable
fill_we_d  out  1  D-cache data array write enable
tag_we_i  out  1  I-cache tag/valid write enable
tag_we_d  out  1  D-cache tag/valid write enable
i_fill_done  out  1  one-cycle pulse: I fill complete
d_fill_done  out  1  one-cycle pulse: D fill complete
d_wr_ack  out  1  one-cycle pulse: store issued to memory
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; issue and receive counters go to 0; owner is cleared.
  - All outputs are 0, including mem_addr, mem_wdata, fill_data and fill_word.
- States: IDLE, WRITE, FILL, DONE.
- Owner register (I or D) is latched on entry to FILL.
- IDLE priority, evaluated in the same cycle: d_wr_req > d_miss_req > i_miss_req.
  - d_wr_req goes to WRITE.
  - A miss request goes to FILL.
  - The block base (addr with bits [3:0] cleared) is latched on entry to FILL.
- WRITE (exactly 1 cycle):
  - Drives mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1.
  - Then returns to IDLE.
  - The requester drops d_wr_req in the cycle after the ack.
- FILL:
  - While issue_cnt < BLOCK_WORDS: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, then issue_cnt++.
  - This gives 8 back-to-back reads.
  - On each mem_rvalid: fill_data=mem_rdata, fill_word=recv_cnt, owner's fill_we=1, then recv_cnt++.
  - The controller counts mem_rvalid pulses, never cycles, so it is latency-agnostic.
  - On the last word (recv_cnt=7 with rvalid), the owner's tag_we=1 in the same cycle as its fill_we; next state is DONE.
- DONE (1 cycle):
  - The owner's *_fill_done=1; counters clear; next state is IDLE.
  - Requests are ignored in DONE.
  - The requester must drop its req by the IDLE cycle that follows.
- No preemption: a fill runs to completion even if higher-priority requests arrive mid-fill.
- Pending requests are serviced from IDLE after DONE.
- mem_rvalid while in IDLE/WRITE/DONE is ignored: no fill_we and no tag_we.
- Reset mid-fill:
  - Abort immediately to IDLE; no done pulse.
  - In-flight memory returns after reset are ignored per the rule above.
- Counter width: issue_cnt and recv_cnt are CNT_W+1 bits, so reaching BLOCK_WORDS is representable without wrap.
- Address arithmetic wraps modulo 2^16; a base of 0xFFF0 is legal and issues 0xFFF0..0xFFFE.
- Reference latency with a 4-cycle memory:
  - req seen in IDLE at cycle 0; reads issued cycles 1-8.
  - rvalid/fill_we at cycles 5-12, with tag_we at cycle 12.
  - done at cycle 13; IDLE at cycle 14.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, WRITE, FILL, DONE)
  - owner enum (OWN_I, OWN_D)
  - BLOCK_WORDS and CNT_W constants
  - BLOCK_OFFSET_MASK (16'hFFF0)
- Sub-module fill_counter: an up-counter with clear, enable and terminal flag (count == BLOCK_WORDS).
  - Instantiated twice: once for issue, once for receive.
- FSM, arbitration and output muxing stay in mem_arbiter.

Test Plan:
- I miss at addr 0x0136, memory latency 4:
  - mem_addr 0x0130..0x013E on cycles 1-8.
  - fill_we_i with fill_word 0..7 on cycles 5-12; tag_we_i at 12.
  - i_fill_done pulse at 13; fill_we_d never asserted.
- i_miss_req and d_miss_req rise in the same cycle:
  - D fill completes first (d_fill_done).
  - I fill's first mem_en follows the cycle after IDLE is re-entered.
  - No interleaving of owners.
- d_wr_req (0x2004, 0xBEEF) during an I fill:
  - No write until the I fill's DONE.
  - Then exactly one cycle of mem_wr=1, mem_addr=0x2004, mem_wdata=0xBEEF, d_wr_ack=1.
- d_wr_req and d_miss_req together in IDLE: WRITE first (1 cycle), then D fill from base of d_miss_addr.
- rst asserted on cycle 7 of a fill:
  - Next cycle: all outputs 0, busy=0.
  - Subsequent stale mem_rvalid pulses produce no fill_we or tag_we.
  - No done pulse.
- Miss at 0xFFFA with randomized memory latency 1-10: addresses 0xFFF0..0xFFFE; 8 fill_we in order; tag_we coincident with word 7.
